// File: rtl/simple_bus_alu_regs.sv
// simple_bus_alu_regs
//   Register-mapped slave on the simple bus that launches tinyALU operations.
//   Register writes load the operands and opcode. A START write either launches
//   an ALU command or, when OP is zero, completes at once as a no-op. The block
//   then waits for alu_done, or gives up after TIMEOUT cycles, and captures the
//   result. Status, sticky error/timeout flags and a completed-operation count
//   are readable.
//
// Ports
//   clk, rst_n     clock; asynchronous active-low reset
//   bus_valid      request qualifier (other bus inputs are don't-care when low)
//   bus_op         1 = write, 0 = read
//   bus_addr       word address
//   bus_wr_data    write data
//   bus_rd_data    registered read data, held until the next read
//   alu_start      high for the whole RUN state
//   alu_A/B/op     operands and opcode, driven straight from DATA_A/DATA_B/OP
//   alu_done       completion pulse from the ALU
//   alu_result     ALU result, valid with alu_done
//
// Register offsets (from BASE_ADDR)
//   0 CTRL   (W)  bit0 START, bit1 CLR; reads 0
//   1 DATA_A (RW) [7:0]
//   2 DATA_B (RW) [7:0]
//   3 OP     (RW) [2:0]
//   4 STATUS      bit0 BUSY (RO); bit1 DONE, bit2 ERR, bit3 TMO (sticky, W1C)
//   5 RESULT (RO)
//   6 OP_CNT (RO)
module simple_bus_alu_regs #(
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter int          TIMEOUT   = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bus_valid,
  input  logic        bus_op,
  input  logic [15:0] bus_addr,
  input  logic [15:0] bus_wr_data,
  output logic [15:0] bus_rd_data,
  output logic        alu_start,
  output logic [7:0]  alu_A,
  output logic [7:0]  alu_B,
  output logic [2:0]  alu_op,
  input  logic        alu_done,
  input  logic [15:0] alu_result
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [15:0] OFF_CTRL = 16'd0;
  localparam logic [15:0] OFF_A    = 16'd1;
  localparam logic [15:0] OFF_B    = 16'd2;
  localparam logic [15:0] OFF_OP   = 16'd3;
  localparam logic [15:0] OFF_STS  = 16'd4;
  localparam logic [15:0] OFF_RES  = 16'd5;
  localparam logic [15:0] OFF_CNT  = 16'd6;

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state;
  state_t           next_state;
  logic [7:0]       data_a;
  logic [7:0]       data_b;
  logic [2:0]       op_reg;
  logic [15:0]      result;
  logic [15:0]      op_cnt;
  logic             sts_done;
  logic             sts_err;
  logic             sts_tmo;
  logic [CNT_W-1:0] tmo_cnt;

  logic [15:0] offset;
  logic        wr_en;
  logic        rd_en;
  logic        busy;
  logic        wr_ctrl;
  logic        wr_a;
  logic        wr_b;
  logic        wr_op;
  logic        wr_sts;
  logic        start_req;
  logic        clr_req;
  logic        launch;
  logic        no_op;
  logic        complete;
  logic        timeout;
  logic        done_set;
  logic        err_set;
  logic [15:0] rd_mux;
  logic        unused_wr_bits;

  // Request decode
  assign offset    = bus_addr - BASE_ADDR;
  assign wr_en     = bus_valid & bus_op;
  assign rd_en     = bus_valid & ~bus_op;
  assign busy      = (state == RUN);

  assign wr_ctrl   = wr_en && (offset == OFF_CTRL);
  assign wr_a      = wr_en && (offset == OFF_A);
  assign wr_b      = wr_en && (offset == OFF_B);
  assign wr_op     = wr_en && (offset == OFF_OP);
  assign wr_sts    = wr_en && (offset == OFF_STS);

  assign start_req = wr_ctrl & bus_wr_data[0];
  assign clr_req   = wr_ctrl & bus_wr_data[1];
  assign launch    = start_req & ~busy & (op_reg != 3'd0);
  assign no_op     = start_req & ~busy & (op_reg == 3'd0);
  assign complete  = busy & alu_done;
  // alu_done in the last allowed cycle still counts as a completion
  assign timeout   = busy & ~alu_done & (tmo_cnt == CNT_LAST);
  assign done_set  = complete | no_op;
  // Unmapped writes, timeouts and writes that would disturb a running command
  assign err_set   = (wr_en && (offset > OFF_CNT)) | timeout |
                     (busy & (start_req | wr_a | wr_b | wr_op));

  assign unused_wr_bits = &{1'b0, bus_wr_data[15:8]};

  // alu_start follows the state flop, so it falls with an asynchronous reset
  assign alu_start = busy;
  assign alu_A     = data_a;
  assign alu_B     = data_b;
  assign alu_op    = op_reg;

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (launch) next_state = RUN;
      RUN:     if (complete || timeout) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    rd_mux = 16'h0000;
    case (offset)
      OFF_A:   rd_mux = {8'h00, data_a};
      OFF_B:   rd_mux = {8'h00, data_b};
      OFF_OP:  rd_mux = {13'd0, op_reg};
      OFF_STS: rd_mux = {12'd0, sts_tmo, sts_err, sts_done, busy};
      OFF_RES: rd_mux = result;
      OFF_CNT: rd_mux = op_cnt;
      default: rd_mux = 16'h0000;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Register update stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_a      <= '0;
      data_b      <= '0;
      op_reg      <= '0;
      result      <= '0;
      op_cnt      <= '0;
      sts_done    <= 1'b0;
      sts_err     <= 1'b0;
      sts_tmo     <= 1'b0;
      tmo_cnt     <= '0;
      bus_rd_data <= '0;
    end else begin
      if (wr_a  && !busy) data_a <= bus_wr_data[7:0];
      if (wr_b  && !busy) data_b <= bus_wr_data[7:0];
      if (wr_op && !busy) op_reg <= bus_wr_data[2:0];

      // A completion in the same cycle as CLR keeps the fresh result
      if (complete)     result <= alu_result;
      else if (clr_req) result <= '0;

      if (clr_req)       op_cnt <= done_set ? 16'd1 : 16'd0;
      else if (done_set) op_cnt <= op_cnt + 16'd1;

      // Sticky flags: a set in the same cycle as a W1C wins
      if (done_set)                      sts_done <= 1'b1;
      else if (wr_sts && bus_wr_data[1]) sts_done <= 1'b0;
      if (err_set)                       sts_err  <= 1'b1;
      else if (wr_sts && bus_wr_data[2]) sts_err  <= 1'b0;
      if (timeout)                       sts_tmo  <= 1'b1;
      else if (wr_sts && bus_wr_data[3]) sts_tmo  <= 1'b0;

      if (busy && next_state == RUN) tmo_cnt <= tmo_cnt + CNT_W'(1);
      else                           tmo_cnt <= '0;

      if (rd_en) bus_rd_data <= rd_mux;
    end
  end

endmodule

// File: doc/simple_bus_alu_regs.md
Name: simple_bus_alu_regs

Overview:
- Register-mapped slave on the simple bus. It consumes the requests the simple bus driver produces (valid/op/addr/wr_data) and returns bus_rd_data.
- Converts register writes into tinyALU command launches (A, B, op, start), waits for done, and captures the result.
- Sits directly downstream of the simple bus master and directly upstream of tinyalu.
- Provides status, sticky error and operation-count registers for tests, including reset-mid-operation tests.

Parameters:
- BASE_ADDR, 16'h0000, word address of register offset 0.
- TIMEOUT, 64, maximum RUN cycles to wait for alu_done before aborting (must be >= 2).

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst_n  input  1  asynchronous active-low reset.
- bus_valid  input  1  request qualifier; all other bus inputs are don't-care when 0.
- bus_op  input  1  1 = write, 0 = read.
- bus_addr  input  16  word address.
- bus_wr_data  input  16  write data.
- bus_rd_data  output  16  registered read data.
- alu_start  output  1  held high until alu_done or timeout.
- alu_A  output  8  operand A (from DATA_A[7:0]).
- alu_B  output  8  operand B (from DATA_B[7:0]).
- alu_op  output  3  opcode (from OP[2:0]).
- alu_done  input  1  ALU completion pulse.
- alu_result  input  16  ALU result, valid when alu_done = 1.

Behaviour:

Reset:
- Asynchronous, active-low.
- All registers, the FSM and all outputs go to 0: bus_rd_data = 0, alu_start = 0, alu_A/B/op = 0, state = IDLE.

Bus protocol:
- A request is taken at any posedge with bus_valid = 1. There is no back-pressure and no wait states.
- Read: bus_rd_data is loaded at that same edge and held until the next read. The master samples it on the following edge.
- Write: takes effect at that same edge.

Register map (offset = bus_addr - BASE_ADDR):
- 0 CTRL (W):
  - bit0 START: write 1 launches an operation; self-clearing.
  - bit1 CLR: clears RESULT and OP_CNT.
  - Reads return 0.
- 1 DATA_A (RW): bits [7:0]; bits [15:8] read 0.
- 2 DATA_B (RW): bits [7:0]; bits [15:8] read 0.
- 3 OP (RW): bits [2:0]; bits [15:3] read 0.
- 4 STATUS:
  - bit0 BUSY (RO).
  - bit1 DONE, bit2 ERR, bit3 TMO: sticky, write-1-to-clear.
- 5 RESULT (RO): 16 bits.
- 6 OP_CNT (RO): 16-bit count of completed operations; wraps 0xFFFF -> 0x0000.
- Any other offset: read returns 16'h0000; write is ignored and sets ERR.
- A write to an RO register is ignored and does not set ERR.

FSM (IDLE, RUN):
- IDLE + START with OP != 0:
  - Next edge: RUN, alu_start = 1.
  - alu_A/B/op are driven from registers continuously; they are frozen by rule while BUSY.
  - BUSY = 1 while in RUN.
- IDLE + START with OP == 0 (no_op): no launch. DONE set and OP_CNT increments at that edge; RESULT unchanged.
- RUN + alu_done = 1:
  - RESULT <= alu_result; DONE set; OP_CNT++.
  - alu_start = 0 and state = IDLE from the next cycle.
- RUN timeout: when the cycle counter reaches TIMEOUT without alu_done:
  - alu_start = 0, TMO and ERR set, return to IDLE.
  - RESULT and OP_CNT unchanged.
- While BUSY:
  - Writes to DATA_A/DATA_B/OP/CTRL.START are ignored and set ERR.
  - CTRL.CLR is honoured.
  - Reads are always serviced.
- alu_done in IDLE is ignored.

Simultaneous events:
- STATUS W1C of DONE in the same cycle that DONE is set: the set wins.
- CLR in the same cycle as completion: the completion wins for RESULT; OP_CNT becomes 1.

Reset mid-RUN:
- alu_start drops asynchronously.
- All state returns to 0; no partial result is captured.

Test Plan:
- Reset, then read offsets 0..6 -> all return 16'h0000; alu_start = 0.
- Write A=8'h12, B=8'h34, OP=3'd1, CTRL=1; ALU model returns done after 3 cycles with 16'h0046 -> alu_start high exactly until done; STATUS reads 16'h0002 afterwards; RESULT = 16'h0046; OP_CNT = 1.
- While BUSY (model delays done), write A=8'hFF -> DATA_A still 8'h12; STATUS = 16'h0005 (BUSY and ERR) during RUN; write STATUS=16'h0006 after completion -> STATUS = 16'h0000.
- OP=3'd4, model never asserts done -> alu_start falls after 64 cycles; STATUS = 16'h000C; RESULT unchanged.
- OP=0, START -> no alu_start pulse; DONE = 1; OP_CNT increments. Then read address 16'h0010 -> 16'h0000; write to it -> ERR set.
- Assert rst_n low two cycles into RUN -> alu_start low immediately; after release all registers read 0; the ALU's later done pulse is ignored.
